// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first,
// repeated a programmable number of times with an optional idle gap between repetitions.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pat_q        <= '0;
            reps_q       <= '0;
            gap_q        <= '0;
            gcnt_q       <= '0;
            bit_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            reps_q       <= reps_d;
            gap_q        <= gap_d;
            gcnt_q       <= gcnt_d;
            bit_q        <= bit_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // reps_q holds the repetitions still owed, including the one being shifted.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d   = pattern;
                    reps_d  = reps;
                    gap_d   = gap;
                    bit_d   = MSB_IDX;
                    state_d = (reps == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    pat_d   = '0;
                    reps_d  = '0;
                    gap_d   = '0;
                    gcnt_d  = '0;
                    bit_d   = '0;
                end else if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else begin
                    reps_d = reps_q - CNT_W'(1);
                    if (reps_q > CNT_W'(1)) begin
                        bit_d = MSB_IDX;
                        if (gap_q == '0) begin
                            state_d = SHIFT;
                        end else begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    pat_d   = '0;
                    reps_d  = '0;
                    gap_d   = '0;
                    gcnt_d  = '0;
                    bit_d   = '0;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    state_d = SHIFT;
                    gcnt_d  = '0;
                    bit_d   = MSB_IDX;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they can be registered without lag.
    always_comb begin
        dout_d       = (state_d == SHIFT) ? pat_d[bit_d] : 1'b0;
        dout_valid_d = (state_d == SHIFT);
        last_d       = (state_d == SHIFT) && (bit_d == '0);
        busy_d       = (state_d == SHIFT) || (state_d == GAP);
        done_d       = (state_d == DONE);
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected per-cycle output vectors are queued
// when a transmission is started and popped one per cycle as the DUT runs.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       dout;
    logic       dout_valid;
    logic       last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .dout      (dout),
        .dout_valid(dout_valid),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Vector order: {dout, dout_valid, last, busy, done}
    task automatic gen_expect(input logic [3:0] p, input int r, input int g);
        for (int i = 0; i < r; i++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({p[b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (i < r - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endtask

    task automatic send(input string name, input logic [3:0] p, input int r, input int g,
                        input bit poke, output int busy_n, output int hits, output int done_at);
        logic [4:0] exp;
        logic [4:0] obs;
        logic [3:0] hist;
        int idx;
        gen_expect(p, r, g);
        pattern = p;
        reps    = r[7:0];
        gap     = g[3:0];
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        idx = 0; hist = '0; busy_n = 0; hits = 0; done_at = -1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = {dout, dout_valid, last, busy, done};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle E+%0d: {dout,valid,last,busy,done} got %b expected %b",
                         name, idx + 1, obs, exp);
            end
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = idx + 1;
            hist = {hist[2:0], dout};
            if (dout_valid && hist == 4'b1011) hits++;
            if (poke && idx == 1) begin
                pattern = 4'b0100; reps = 8'd1; gap = 4'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            idx++;
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; abort = 1'b0; pattern = 4'b1011; reps = 8'd1; gap = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({dout, dout_valid, last, busy, done} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected 00000", i,
                         {dout, dout_valid, last, busy, done});
            end
        end
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({dout, dout_valid, last, busy, done} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %b expected 00000", i,
                         {dout, dout_valid, last, busy, done});
            end
        end
    endtask

    task automatic test_single;
        int bn, h, da;
        send("single", 4'b1011, 1, 0, 1'b0, bn, h, da);
        checks++;
        if (bn !== 4 || h !== 1 || da !== 5) begin
            errors++;
            $display("FAIL single_summary: busy=%0d hits=%0d done_at=E+%0d expected 4 1 5", bn, h, da);
        end
    endtask

    task automatic test_back_to_back;
        int bn, h, da;
        send("back_to_back", 4'b1011, 3, 0, 1'b0, bn, h, da);
        checks++;
        if (bn !== 12 || h !== 3 || da !== 13) begin
            errors++;
            $display("FAIL b2b_summary: busy=%0d hits=%0d done_at=E+%0d expected 12 3 13", bn, h, da);
        end
    endtask

    task automatic test_gap;
        int bn, h, da;
        send("gap", 4'b1011, 2, 2, 1'b1, bn, h, da);
        checks++;
        if (bn !== 10 || da !== 11) begin
            errors++;
            $display("FAIL gap_summary: busy=%0d done_at=E+%0d expected 10 11", bn, da);
        end
    endtask

    task automatic test_zero_reps;
        int bn, h, da;
        send("zero_reps", 4'b1111, 0, 3, 1'b0, bn, h, da);
        checks++;
        if (bn !== 0 || da !== 1) begin
            errors++;
            $display("FAIL zero_reps_summary: busy=%0d done_at=E+%0d expected 0 1", bn, da);
        end
    endtask

    task automatic test_abort_start;
        pattern = 4'b1011; reps = 8'd2; gap = 4'd0;
        abort = 1'b1; start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if ({dout, dout_valid, last, busy, done} !== 5'b00000) begin
                errors++;
                $display("FAIL abort_start cycle %0d: got %b expected 00000", i,
                         {dout, dout_valid, last, busy, done});
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_abort;
        logic [4:0] exp;
        int bn, h, da;
        // abort sampled at the edge closing the 6th busy cycle
        gen_expect(4'b1011, 4, 0);
        pattern = 4'b1011; reps = 8'd4; gap = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if ({dout, dout_valid, last, busy, done} !== exp) begin
                errors++;
                $display("FAIL abort_pre cycle E+%0d: got %b expected %b", i + 1,
                         {dout, dout_valid, last, busy, done}, exp);
            end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        exp_q.delete();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dout, dout_valid, last, busy, done} !== 5'b00000) begin
                errors++;
                $display("FAIL abort_post cycle %0d: got %b expected 00000", i,
                         {dout, dout_valid, last, busy, done});
            end
            @(posedge clk); #1;
        end
        // reset asserted during the first gap cycle
        gen_expect(4'b1011, 4, 3);
        pattern = 4'b1011; reps = 8'd4; gap = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if ({dout, dout_valid, last, busy, done} !== exp) begin
                errors++;
                $display("FAIL rst_gap_pre cycle E+%0d: got %b expected %b", i + 1,
                         {dout, dout_valid, last, busy, done}, exp);
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dout, dout_valid, last, busy, done} !== 5'b00000) begin
                errors++;
                $display("FAIL rst_gap_post cycle %0d: got %b expected 00000", i,
                         {dout, dout_valid, last, busy, done});
            end
            @(posedge clk); #1;
        end
        send("after_abort", 4'b1101, 2, 1, 1'b0, bn, h, da);
        checks++;
        if (bn !== 9 || da !== 10) begin
            errors++;
            $display("FAIL after_abort_summary: busy=%0d done_at=E+%0d expected 9 10", bn, da);
        end
    endtask

    task automatic test_max_reps;
        int bn, h, da;
        send("max_reps", 4'b1011, 255, 0, 1'b0, bn, h, da);
        checks++;
        if (bn !== 1020 || h !== 255 || da !== 1021) begin
            errors++;
            $display("FAIL max_reps_summary: busy=%0d hits=%0d done_at=E+%0d expected 1020 255 1021",
                     bn, h, da);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0; gap = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_reps();
        test_abort_start();
        test_abort();
        test_max_reps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
